// File: rtl/gate_sweep_ctrl.sv
// Sweeps a 2-input gate through all four input vectors, captures its truth table
// and compares it with a latched expected table.
module gate_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_gate_y,
  input  logic [3:0] i_expected,
  output logic       o_gate_a,
  output logic       o_gate_b,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_table,
  output logic       o_pass,
  output logic [2:0] o_mismatch_cnt,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FIN    = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;
  logic [3:0] r_exp;
  logic [3:0] r_table;
  logic       r_pass;
  logic [2:0] r_mismatch_cnt;

  logic [3:0] w_table_smp;
  logic [3:0] w_diff;
  logic [2:0] w_popcnt;

  // Table as it looks after this cycle's sample; the last sample feeds the compare directly.
  always_comb begin
    w_table_smp        = r_table;
    w_table_smp[r_idx] = i_gate_y;
    w_diff             = w_table_smp ^ r_exp;
    w_popcnt           = 3'(w_diff[0]) + 3'(w_diff[1]) + 3'(w_diff[2]) + 3'(w_diff[3]);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_state_next = ST_SETTLE;
      ST_SETTLE: if (r_cnt == SETTLE_LAST) w_state_next = ST_SAMPLE;
      ST_SAMPLE: w_state_next = (r_idx == 2'd3) ? ST_FIN : ST_SETTLE;
      ST_FIN:    w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx          <= 2'd0;
      r_cnt          <= 4'd0;
      r_exp          <= 4'd0;
      r_table        <= 4'd0;
      r_pass         <= 1'b0;
      r_mismatch_cnt <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_exp          <= i_expected;
            r_table        <= 4'd0;
            r_pass         <= 1'b0;
            r_mismatch_cnt <= 3'd0;
            r_idx          <= 2'd0;
            r_cnt          <= 4'd0;
          end
        end
        ST_SETTLE: r_cnt <= r_cnt + 4'd1;
        ST_SAMPLE: begin
          r_table <= w_table_smp;
          if (r_idx == 2'd3) begin
            r_pass         <= (w_diff == 4'd0);
            r_mismatch_cnt <= w_popcnt;
          end else begin
            r_idx <= r_idx + 2'd1;
            r_cnt <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // o_done is the single-cycle valid for o_table/o_pass/o_mismatch_cnt; there is no
  // ready, and the results stay stable afterwards until the next accepted start.
  assign o_gate_a       = r_idx[0];
  assign o_gate_b       = r_idx[1];
  assign o_busy         = (r_state != ST_IDLE);
  assign o_done         = (r_state == ST_FIN);
  assign o_table        = r_table;
  assign o_pass         = r_pass;
  assign o_mismatch_cnt = r_mismatch_cnt;
  assign o_state        = r_state;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) driving a modelled gate,
// with result/latency scoreboards popped on each done pulse.
module tb_gate_sweep_ctrl;

  localparam int W = 8; // {table[3:0], pass, mismatch_cnt[2:0]}

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_miss;

  logic       start1, gy1, ga1, gb1, busy1, done1, pass1;
  logic [3:0] exp1, table1;
  logic [2:0] mm1;
  logic [1:0] st1, sel1;

  logic       start3, gy3, ga3, gb3, busy3, done3, pass3;
  logic [3:0] exp3, table3;
  logic [2:0] mm3;
  logic [1:0] st3, sel3;

  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q3[$];
  int           lat_q1[$];
  int           lat_q3[$];

  gate_sweep_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .i_gate_y(gy1), .i_expected(exp1),
    .o_gate_a(ga1), .o_gate_b(gb1), .o_busy(busy1), .o_done(done1), .o_table(table1),
    .o_pass(pass1), .o_mismatch_cnt(mm1), .o_state(st1)
  );

  gate_sweep_ctrl #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_start(start3), .i_gate_y(gy3), .i_expected(exp3),
    .o_gate_a(ga3), .o_gate_b(gb3), .o_busy(busy3), .o_done(done3), .o_table(table3),
    .o_pass(pass3), .o_mismatch_cnt(mm3), .o_state(st3)
  );

  // Gate under test: 0 AND, 1 OR, 2 XOR, 3 NAND
  function automatic logic gate_f(input logic [1:0] sel, input logic a, input logic b);
    case (sel)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  assign gy1 = gate_f(sel1, ga1, gb1);
  assign gy3 = gate_f(sel3, ga3, gb3);

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitors
  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (exp_q1.size() == 0) begin
        check("extra_done1", 32'(done1), 32'd0);
      end else begin
        check("result1", 32'({table1, pass1, mm1}), 32'(exp_q1.pop_front()));
        check("latency1", 32'(cyc), 32'(lat_q1.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done3) begin
      if (exp_q3.size() == 0) begin
        check("extra_done3", 32'(done3), 32'd0);
      end else begin
        check("result3", 32'({table3, pass3, mm3}), 32'(exp_q3.pop_front()));
        check("latency3", 32'(cyc), 32'(lat_q3.pop_front()));
      end
    end
  end

  // drivers
  task automatic sweep1(input logic [1:0] sel, input logic [3:0] expv, input logic [W-1:0] res);
    @(negedge clk);
    sel1   = sel;
    exp1   = expv;
    start1 = 1'b1;
    exp_q1.push_back(res);
    lat_q1.push_back(cyc + 1 + 4 * 2);
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic sweep3(input logic [1:0] sel, input logic [3:0] expv, input logic [W-1:0] res);
    @(negedge clk);
    sel3   = sel;
    exp3   = expv;
    start3 = 1'b1;
    exp_q3.push_back(res);
    lat_q3.push_back(cyc + 1 + 4 * 4);
    @(negedge clk);
    start3 = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && (exp_q1.size() > 0 || exp_q3.size() > 0); i++) @(negedge clk);
    if (exp_q1.size() > 0 || exp_q3.size() > 0) begin
      check(name, 32'(exp_q1.size() + exp_q3.size()), 32'd0);
      exp_q1.delete(); lat_q1.delete();
      exp_q3.delete(); lat_q3.delete();
    end
  endtask

  task automatic check_idle1(input string name, input logic [W-1:0] res, input logic [1:0] vec);
    repeat (4) @(negedge clk);
    check({name, "_hold"}, 32'({table1, pass1, mm1}), 32'(res));
    check({name, "_vec"}, 32'({gb1, ga1, busy1, st1}), 32'({vec, 1'b0, 2'd0}));
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    rst_n = 1'b0;
    start1 = 1'b0; sel1 = 2'd0; exp1 = 4'd0;
    start3 = 1'b0; sel3 = 2'd0; exp3 = 4'd0;
    #1;
    check("reset_outputs", 32'({ga1, gb1, busy1, done1, table1, pass1, mm1, st1}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // AND, expected 1000
    sweep1(2'd0, 4'b1000, 8'b1000_1_000);
    drain("timeout_and");
    check_idle1("and", 8'b1000_1_000, 2'b11);

    // OR, expected 1000
    sweep1(2'd1, 4'b1000, 8'b1110_0_010);
    drain("timeout_or");

    // XOR against 1001: every bit differs
    sweep1(2'd2, 4'b1001, 8'b0110_0_100);
    drain("timeout_xor4");

    // XOR on the SETTLE=3 instance
    sweep3(2'd2, 4'b0110, 8'b0110_1_000);
    drain("timeout_xor3");

    // start re-pulsed in SETTLE and in FIN
    sweep1(2'd0, 4'b1000, 8'b1000_1_000);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 50 && !done1; i++) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    drain("timeout_restart");
    repeat (12) @(negedge clk);
    check("restart_idle", 32'({busy1, st1}), 32'd0);
    check_idle1("restart", 8'b1000_1_000, 2'b11);

    // reset during vector 2
    @(negedge clk);
    sel1 = 2'd0; exp1 = 4'b1000; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    check("vec2_reached", 32'({gb1, ga1, busy1}), 32'b101);
    rst_n = 1'b0;
    #1;
    check("midsweep_reset", 32'({ga1, gb1, busy1, done1, table1, pass1, mm1, st1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep1(2'd3, 4'b0111, 8'b0111_1_000);
    drain("timeout_nand");

    // expected changes after acceptance
    sweep1(2'd0, 4'b1000, 8'b1000_1_000);
    repeat (3) @(negedge clk);
    exp1 = 4'b0000;
    drain("timeout_expchg");
    check_idle1("expchg", 8'b1000_1_000, 2'b11);

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
